// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped instruction cache with single-word miss fill
//
// Purpose: flop-based direct-mapped I-cache. A lookup hit is answered in the
// same cycle. A miss latches the word address and runs a single-word read
// on the iREN/iaddr/iwait/iload handshake. Only one request is outstanding.
//
// Ports:
//   CLK, nRST             clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr     fetch request and byte address from the datapath
//   ihit, imemload        hit flag and instruction word (zero when no hit)
//   flush                 invalidate every frame
//   iREN, iaddr           memory read request and word-aligned address
//   iwait, iload          memory busy flag and read data (valid when iwait=0)
//   hit_count, miss_count saturating counters (only with ICACHE_PERF_EN)
//
// Optional feature macro: ICACHE_PERF_EN
module icache_direct #(
  parameter int NSETS  = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  input  logic              flush,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_PERF_EN
  ,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nx;

  logic [NSETS-1:0]  valid;
  logic [TAG_W-1:0]  tags [NSETS];
  logic [WORD_W-1:0] data [NSETS];
  logic [WORD_W-1:0] miss_addr;

  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic             lookup_hit, start_fill, fill_done;
  logic             unused_offset;

  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[WORD_W-1:IDX_W+2];
  // Byte offset within the word plays no part in an instruction fetch.
  assign unused_offset = ^imemaddr[1:0];

  assign lookup_hit = imemREN & valid[idx] & (tags[idx] == tag) & (state == IDLE) & ~flush;
  assign ihit       = lookup_hit;
  assign imemload   = lookup_hit ? data[idx] : '0;
  assign start_fill = (state == IDLE) & imemREN & ~lookup_hit & ~flush;
  assign fill_done  = (state == FILL) & ~iwait;

  always_comb begin
    state_nx = state;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state)
      IDLE: if (start_fill) state_nx = FILL;
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        // Once issued, the read always runs to completion.
        if (!iwait) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      valid     <= '0;
    end else begin
      state <= state_nx;
      if (start_fill) miss_addr <= {imemaddr[WORD_W-1:2], 2'b00};
      // Flush wins over a fill landing on the same edge: that frame ends invalid.
      if (flush)          valid           <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset; valid alone qualifies them.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit && !(&hit_count))  hit_count  <= hit_count + 1'b1;
      if (start_fill && !(&miss_count)) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule
